// File: rtl/mux8_arb_pkg.sv
// Shared constants, FSM state type and the round-robin pick function for the
// 8:1 mux arbiter.
package mux8_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Returns {found, idx}: the first set request at or after ptr, modulo N_REQ.
  function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [SEL_W-1:0] ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   off;
    logic               found;
    dbl   = {req, req};
    rot   = dbl[ptr +: N_REQ];
    off   = '0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = i[SEL_W-1:0];
      end
    end
    return {found, SEL_W'(ptr + off)};
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotate / priority-encode / un-rotate picker: first requester
// at or after ptr, wrapping 7->0.
import mux8_arb_pkg::*;

module rr_pick8 (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  assign {found, idx} = rr_pick(req, ptr);

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select lines of the 8:1 mux, with a bounded
// hold tenure. Optional urgent requester 7 via `define MUX8_ARB_PRIO7_EN.
//
// state | meaning
// IDLE  | no grant; sel holds last winner
// BUSY  | gnt[sel] held; hold_left counts remaining tenure down to 0
import mux8_arb_pkg::*;

module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             grant_valid,
  output logic             forced_release
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  state_t             state, state_n;
  logic [SEL_W-1:0]   ptr, ptr_n, sel_n, search_ptr, rr_idx, pick_idx;
  logic [N_REQ-1:0]   gnt_n;
  logic [CNT_W-1:0]   hold_left, hold_left_n;
  logic               fr_n, rr_found, pick_found, holder_req, release_now, preempt;

  // On a release edge the search starts just past the current holder.
  assign search_ptr = (state == BUSY) ? SEL_W'(sel + 1'b1) : ptr;
  assign holder_req = req[sel];

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (search_ptr),
    .found (rr_found),
    .idx   (rr_idx)
  );

`ifdef MUX8_ARB_PRIO7_EN
  logic req7_q, urgent;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) req7_q <= 1'b0;
    else     req7_q <= req[N_REQ-1];
  end

  // A timed-out requester 7 falls back to plain round robin so others get a turn.
  assign urgent     = req[N_REQ-1] && !((state == BUSY) && (sel == SEL_W'(N_REQ-1)));
  assign preempt    = (state == BUSY) && (sel != SEL_W'(N_REQ-1)) && req[N_REQ-1] && !req7_q;
  assign pick_found = rr_found || urgent;
  assign pick_idx   = urgent ? SEL_W'(N_REQ-1) : rr_idx;
`else
  assign preempt    = 1'b0;
  assign pick_found = rr_found;
  assign pick_idx   = rr_idx;
`endif

  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    sel_n       = sel;
    ptr_n       = ptr;
    hold_left_n = hold_left;
    fr_n        = 1'b0;
    release_now = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_n     = BUSY;
          gnt_n       = N_REQ'(1) << pick_idx;
          sel_n       = pick_idx;
          hold_left_n = CNT_W'(MAX_HOLD - 1);
        end
      end
      BUSY: begin
        if (!holder_req) begin
          release_now = 1'b1;
        end else if (hold_left == '0 || preempt) begin
          release_now = 1'b1;
          fr_n        = 1'b1;
        end else begin
          hold_left_n = hold_left - 1'b1;
        end
        if (release_now) begin
          ptr_n = SEL_W'(sel + 1'b1);
          if (pick_found) begin
            gnt_n       = N_REQ'(1) << pick_idx;
            sel_n       = pick_idx;
            hold_left_n = CNT_W'(MAX_HOLD - 1);
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      gnt            <= '0;
      sel            <= '0;
      ptr            <= '0;
      hold_left      <= '0;
      forced_release <= 1'b0;
    end else begin
      state          <= state_n;
      gnt            <= gnt_n;
      sel            <= sel_n;
      ptr            <= ptr_n;
      hold_left      <= hold_left_n;
      forced_release <= fr_n;
    end
  end

  assign grant_valid = (state == BUSY);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_mux8_rr_arbiter;

  localparam int MAX_HOLD = 4;
`ifdef MUX8_ARB_PRIO7_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       grant_valid;
  logic       forced_release;

  mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .gnt            (gnt),
    .sel            (sel),
    .grant_valid    (grant_valid),
    .forced_release (forced_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [7:0] g, input logic [2:0] s,
                         input logic v, input logic f);
    chk({name, "_gnt"}, 32'(gnt), 32'(g));
    chk({name, "_sel"}, 32'(sel), 32'(s));
    chk({name, "_valid"}, 32'(grant_valid), 32'(v));
    chk({name, "_fr"}, 32'(forced_release), 32'(f));
  endtask

  task automatic cycle(input logic [7:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       fr;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic [7:0] r, input logic [7:0] g, input logic [2:0] s,
                              input logic v, input logic f);
    vecs.push_back('{r, g, s, v, f});
  endfunction

  // Behavioural model: tenure counted up 1..MAX_HOLD, pick by modular scan.
  int   m_busy, m_h, m_cnt, m_ptr, m_sel;
  logic m_fr, m_r7q;

  function automatic int pick_from(input logic [7:0] r, input int start, input bit urgent_ok);
    if (PRIO && urgent_ok && r[7]) return 7;
    for (int i = 0; i < 8; i++)
      if (r[(start + i) % 8]) return (start + i) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_h = 0; m_cnt = 0; m_ptr = 0; m_sel = 0; m_fr = 1'b0; m_r7q = 1'b0;
  endtask

  task automatic model_update(input logic [7:0] r);
    int p;
    bit pre;
    m_fr = 1'b0;
    pre  = PRIO && (m_busy != 0) && (m_h != 7) && r[7] && !m_r7q;
    if (m_busy == 0) begin
      p = pick_from(r, m_ptr, 1'b1);
      if (p >= 0) begin m_busy = 1; m_h = p; m_sel = p; m_cnt = 1; end
    end else if (r[m_h] && m_cnt < MAX_HOLD && !pre) begin
      m_cnt++;
    end else begin
      m_fr  = r[m_h];
      m_ptr = (m_h + 1) % 8;
      p = pick_from(r, m_ptr, m_h != 7);
      if (p >= 0) begin m_h = p; m_sel = p; m_cnt = 1; end
      else m_busy = 0;
    end
    m_r7q = r[7];
  endtask

  initial begin
    logic [7:0] exp_g, cur;
    int         h;

    rst = 1'b1;
    req = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);

    // single request, wrap/skip from ptr=6, sole-requester timeout
    add(8'h08, 8'h08, 3'd3, 1, 0);
    add(8'h08, 8'h08, 3'd3, 1, 0);
    add(8'h08, 8'h08, 3'd3, 1, 0);
    add(8'h00, 8'h00, 3'd3, 0, 0);
    add(8'h20, 8'h20, 3'd5, 1, 0);
    add(8'h03, 8'h01, 3'd0, 1, 0);
    add(8'h03, 8'h01, 3'd0, 1, 0);
    add(8'h02, 8'h02, 3'd1, 1, 0);
    add(8'h00, 8'h00, 3'd1, 0, 0);
    for (int c = 0; c < 10; c++)
      add(8'h20, 8'h20, 3'd5, 1, (c == 4 || c == 8) ? 1'b1 : 1'b0);
    add(8'h00, 8'h00, 3'd5, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].req);
      chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].valid, vecs[i].fr);
    end

`ifndef MUX8_ARB_PRIO7_EN
    // all requesting: 4-cycle tenures rotating from ptr=6, no gaps
    for (int c = 0; c < 36; c++) begin
      cycle(8'hFF);
      h = (6 + c / 4) % 8;
      chk_out($sformatf("rr%0d", c), 8'(1 << h), 3'(h), 1'b1, (c > 0 && c % 4 == 0));
    end
`endif

    // async reset mid-tenure
    cycle(8'hFF);
    cycle(8'hFF);
    #2;
    rst = 1'b1;
    #1;
    chk_out("rst_mid", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    req = 8'h00;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle(8'h00);
      chk_out($sformatf("rst_idle%0d", c), 8'h00, 3'd0, 1'b0, 1'b0);
    end

    // requester 7 arriving while 2 holds
    cycle(8'h04);
    chk_out("p7_a", 8'h04, 3'd2, 1'b1, 1'b0);
    cycle(8'h84);
    if (PRIO) chk_out("p7_b", 8'h80, 3'd7, 1'b1, 1'b1);
    else      chk_out("p7_b", 8'h04, 3'd2, 1'b1, 1'b0);
    cycle(8'h80);
    chk_out("p7_c", 8'h80, 3'd7, 1'b1, 1'b0);
    cycle(8'h00);
    chk_out("p7_d", 8'h00, 3'd7, 1'b0, 1'b0);

    // randomized run against the model
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    cur = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rnd_rst_gnt", 32'(gnt), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end
      if ($urandom_range(0, 3) == 0)
        cur = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
      req = cur;
      @(posedge clk);
      model_update(cur);
      #1;
      exp_g = (m_busy != 0) ? 8'(1 << m_h) : 8'h00;
      chk("rnd_gnt", 32'(gnt), 32'(exp_g));
      chk("rnd_sel", 32'(sel), 32'(m_sel));
      chk("rnd_valid", 32'(grant_valid), 32'(m_busy != 0));
      chk("rnd_fr", 32'(forced_release), 32'(m_fr));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
